// File: rtl/banked_data_memory.sv
`default_nettype none
// ============================================================================
// Module   : banked_data_memory
// Purpose  : Byte-laned MEM-stage data memory with a valid/ready request port,
//            one-cycle registered response, fault detection and a reset sweep.
// Revision : 1.0
// ============================================================================
module banked_data_memory #(
    parameter int          ADDR_WIDTH     = 12,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter bit          CLEAR_ON_RESET = 1'b1,
    parameter bit          TRACE          = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        reqWrite,
    input  logic [2:0]  reqMode,
    input  logic [31:0] reqAddr,
    input  logic [31:0] reqWData,
    input  logic [31:0] reqPC,
    output logic        respValid,
    output logic [31:0] respRData,
    output logic        respFault,
    output logic        busy
);

    localparam int          c_depth    = 1 << ADDR_WIDTH;
    localparam logic [32:0] c_span     = 33'd4 << ADDR_WIDTH;
    localparam logic [0:0]  c_st_clear = 1'b0;
    localparam logic [0:0]  c_st_ready = 1'b1;

    logic [0:0]          r_state;
    logic [ADDR_WIDTH:0] r_clear_cnt;
    logic                r_valid;
    logic                r_fault;
    logic                r_write;
    logic [2:0]          r_mode;
    logic [1:0]          r_alo;
    logic [7:0]          r_lane [4][c_depth];
    logic [7:0]          r_rd   [4];

    logic [31:0]           w_offset;
    logic                  w_in_range;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic [1:0]            w_size;
    logic                  w_fault;
    logic                  w_accept;
    logic                  w_commit;
    logic [3:0]            w_be;
    logic [31:0]           w_wrep;
    logic [ADDR_WIDTH:0]   w_clear_next;
    logic [31:0]           w_word;
    logic [31:0]           w_shifted;
    logic [31:0]           w_ext;

    assign w_offset     = reqAddr - BASE_ADDR;
    assign w_in_range   = (reqAddr >= BASE_ADDR) && ({1'b0, w_offset} < c_span);
    assign w_idx        = w_offset[ADDR_WIDTH+1:2];
    assign w_size       = reqMode[2:1];
    assign w_fault      = (w_size == 2'd3)
                        | ((w_size == 2'd1) & reqAddr[0])
                        | ((w_size == 2'd0) & (|reqAddr[1:0]))
                        | ~w_in_range;
    assign w_accept     = reqValid & reqReady;
    assign w_commit     = w_accept & reqWrite & ~w_fault;
    assign w_clear_next = r_clear_cnt + (ADDR_WIDTH+1)'(1);

    // Store data is replicated so every enabled lane simply takes its own byte.
    always_comb begin
        w_be   = 4'b1111;
        w_wrep = reqWData;
        case (w_size)
            2'd1: begin
                w_be   = reqAddr[1] ? 4'b1100 : 4'b0011;
                w_wrep = {2{reqWData[15:0]}};
            end
            2'd2: begin
                w_be   = 4'b0001 << reqAddr[1:0];
                w_wrep = {4{reqWData[7:0]}};
            end
            default: begin
                w_be   = 4'b1111;
                w_wrep = reqWData;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= CLEAR_ON_RESET ? c_st_clear : c_st_ready;
            r_clear_cnt <= '0;
            r_valid     <= 1'b0;
            r_fault     <= 1'b0;
            r_write     <= 1'b0;
            r_mode      <= 3'd0;
            r_alo       <= 2'd0;
        end else begin
            r_valid <= w_accept;
            r_fault <= w_accept & w_fault;
            r_write <= reqWrite;
            r_mode  <= reqMode;
            r_alo   <= reqAddr[1:0];
            if (r_state == c_st_clear) begin
                r_clear_cnt <= w_clear_next;
                if (w_clear_next[ADDR_WIDTH]) begin
                    r_state <= c_st_ready;
                end
            end
        end
    end

    // Storage has no reset; the reset level only suppresses writes at that edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (r_state == c_st_clear) begin
                for (int k = 0; k < 4; k++) begin
                    r_lane[k][r_clear_cnt[ADDR_WIDTH-1:0]] <= 8'h00;
                end
            end else if (w_commit) begin
                for (int k = 0; k < 4; k++) begin
                    if (w_be[k]) begin
                        r_lane[k][w_idx] <= w_wrep[8*k +: 8];
                    end
                end
            end
            if (w_accept) begin
                for (int k = 0; k < 4; k++) begin
                    r_rd[k] <= r_lane[k][w_idx];
                end
            end
        end
    end

    assign w_word    = {r_rd[3], r_rd[2], r_rd[1], r_rd[0]};
    assign w_shifted = w_word >> {r_alo, 3'b000};

    always_comb begin
        w_ext = w_word;
        case (r_mode[2:1])
            2'd1:    w_ext = r_mode[0] ? {{16{w_shifted[15]}}, w_shifted[15:0]}
                                       : {16'h0000, w_shifted[15:0]};
            2'd2:    w_ext = r_mode[0] ? {{24{w_shifted[7]}}, w_shifted[7:0]}
                                       : {24'h000000, w_shifted[7:0]};
            default: w_ext = w_word;
        endcase
    end

    assign reqReady  = (r_state == c_st_ready) & reset;
    assign busy      = (r_state == c_st_clear);
    assign respValid = r_valid;
    assign respFault = r_fault;
    assign respRData = (r_valid & ~r_fault & ~r_write) ? w_ext : 32'h0000_0000;

    generate
        if (TRACE) begin : g_trace
`ifndef SYNTHESIS
            logic [31:0] w_merged;
            always_comb begin
                w_merged = '0;
                for (int k = 0; k < 4; k++) begin
                    w_merged[8*k +: 8] = w_be[k] ? w_wrep[8*k +: 8] : r_lane[k][w_idx];
                end
            end
            always @(posedge clk) begin
                if (reset && w_commit) begin
                    $display("%d@%08h: *%08h <= %08h", $time, reqPC,
                             {reqAddr[31:2], 2'b00}, w_merged);
                end
            end
`endif
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_banked_data_memory.sv
`default_nettype none
// ============================================================================
// Module   : tb_banked_data_memory
// Purpose  : Scoreboard bench for banked_data_memory (ADDR_WIDTH=4, BASE=0).
// Revision : 1.0
// ============================================================================
module tb_banked_data_memory;

    localparam int c_aw = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        reqValid = 1'b0;
    logic        reqWrite = 1'b0;
    logic [2:0]  reqMode = 3'd0;
    logic [31:0] reqAddr = 32'h0;
    logic [31:0] reqWData = 32'h0;
    logic [31:0] reqPC = 32'h0000_1000;
    logic        reqReady;
    logic        respValid;
    logic [31:0] respRData;
    logic        respFault;
    logic        busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        fault;
    } exp_t;
    exp_t sb[$];

    banked_data_memory #(
        .ADDR_WIDTH     (c_aw),
        .BASE_ADDR      (32'h0000_0000),
        .CLEAR_ON_RESET (1'b1),
        .TRACE          (1'b1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .reqValid  (reqValid),
        .reqReady  (reqReady),
        .reqWrite  (reqWrite),
        .reqMode   (reqMode),
        .reqAddr   (reqAddr),
        .reqWData  (reqWData),
        .reqPC     (reqPC),
        .respValid (respValid),
        .respRData (respRData),
        .respFault (respFault),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Monitor: every presented response must match the oldest expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (respValid !== 1'b0) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got respValid=%b rdata=%08h expected no response",
                         respValid, respRData);
            end else begin
                e = sb.pop_front();
                check({e.name, "_rdata"}, respRData, e.rdata);
                check({e.name, "_fault"}, {31'b0, respFault}, {31'b0, e.fault});
            end
        end
    end

    task automatic issue(input string name, input logic wr, input logic [2:0] mode,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rd, input logic exp_f);
        exp_t e;
        @(negedge clk);
        reqValid = 1'b1;
        reqWrite = wr;
        reqMode  = mode;
        reqAddr  = addr;
        reqWData = wdata;
        reqPC    = reqPC + 32'd4;
        e.name   = name;
        e.rdata  = exp_rd;
        e.fault  = exp_f;
        sb.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        reqValid = 1'b0;
        reqWrite = 1'b0;
    endtask

    task automatic measure_clear(input string name);
        int cnt   = 0;
        int guard = 0;
        while (reqReady !== 1'b1 && guard < 100) begin
            if (busy === 1'b1) cnt++;
            guard++;
            @(negedge clk);
        end
        check({name, "_cycles"}, 32'(cnt), 32'd16);
        check({name, "_busy_low"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        repeat (3) @(negedge clk);
        check("rst_ready",  {31'b0, reqReady},  32'd0);
        check("rst_valid",  {31'b0, respValid}, 32'd0);
        check("rst_rdata",  respRData,          32'd0);
        check("rst_fault",  {31'b0, respFault}, 32'd0);
        check("rst_busy",   {31'b0, busy},      32'd1);
        reset = 1'b1;
        measure_clear("clear");

        //     name        wr    mode    addr          wdata          exp_rdata      fault
        issue("lw_3c",    1'b0, 3'b000, 32'h0000_003C, 32'h0,          32'h0000_0000, 1'b0);
        issue("sw_10",    1'b1, 3'b000, 32'h0000_0010, 32'hDEAD_BEEF,  32'h0000_0000, 1'b0);
        issue("lw_10",    1'b0, 3'b000, 32'h0000_0010, 32'h0,          32'hDEAD_BEEF, 1'b0);
        issue("sb_21",    1'b1, 3'b100, 32'h0000_0021, 32'h1234_5680,  32'h0000_0000, 1'b0);
        issue("lb_21",    1'b0, 3'b101, 32'h0000_0021, 32'h0,          32'hFFFF_FF80, 1'b0);
        issue("lbu_21",   1'b0, 3'b100, 32'h0000_0021, 32'h0,          32'h0000_0080, 1'b0);
        issue("lw_20",    1'b0, 3'b000, 32'h0000_0020, 32'h0,          32'h0000_8000, 1'b0);
        issue("sh_32",    1'b1, 3'b010, 32'h0000_0032, 32'hABCD_8001,  32'h0000_0000, 1'b0);
        issue("lh_32",    1'b0, 3'b011, 32'h0000_0032, 32'h0,          32'hFFFF_8001, 1'b0);
        issue("lhu_32",   1'b0, 3'b010, 32'h0000_0032, 32'h0,          32'h0000_8001, 1'b0);
        issue("sh_33",    1'b1, 3'b010, 32'h0000_0033, 32'h0000_FFFF,  32'h0000_0000, 1'b1);
        issue("lw_30",    1'b0, 3'b000, 32'h0000_0030, 32'h0,          32'h8001_0000, 1'b0);
        issue("sw_36",    1'b1, 3'b000, 32'h0000_0036, 32'h1111_1111,  32'h0000_0000, 1'b1);
        issue("lw_34",    1'b0, 3'b000, 32'h0000_0034, 32'h0,          32'h0000_0000, 1'b0);
        issue("lw_22",    1'b0, 3'b000, 32'h0000_0022, 32'h0,          32'h0000_0000, 1'b1);
        issue("mode_110", 1'b0, 3'b110, 32'h0000_0000, 32'h0,          32'h0000_0000, 1'b1);
        issue("lw_40",    1'b0, 3'b000, 32'h0000_0040, 32'h0,          32'h0000_0000, 1'b1);
        issue("sw_40",    1'b1, 3'b000, 32'h0000_0040, 32'h7777_7777,  32'h0000_0000, 1'b1);
        issue("lw_00",    1'b0, 3'b000, 32'h0000_0000, 32'h0,          32'h0000_0000, 1'b0);
        issue("sb_3f",    1'b1, 3'b100, 32'h0000_003F, 32'h0000_005A,  32'h0000_0000, 1'b0);
        issue("lw_3c_b",  1'b0, 3'b000, 32'h0000_003C, 32'h0,          32'h5A00_0000, 1'b0);
        issue("lhu_3e",   1'b0, 3'b010, 32'h0000_003E, 32'h0,          32'h0000_5A00, 1'b0);
        issue("lb_3f",    1'b0, 3'b101, 32'h0000_003F, 32'h0,          32'h0000_005A, 1'b0);
        idle();
        repeat (3) @(negedge clk);

        // A load is accepted, then reset drops before its response is sampled.
        reqValid = 1'b1;
        reqWrite = 1'b0;
        reqMode  = 3'b000;
        reqAddr  = 32'h0000_0010;
        @(posedge clk);
        #1;
        reqValid = 1'b0;
        reset    = 1'b0;
        #1;
        check("inflight_valid", {31'b0, respValid}, 32'd0);
        check("inflight_rdata", respRData,          32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        measure_clear("clear_restart");

        issue("lw_10_clr", 1'b0, 3'b000, 32'h0000_0010, 32'h0, 32'h0000_0000, 1'b0);
        issue("lw_30_clr", 1'b0, 3'b000, 32'h0000_0030, 32'h0, 32'h0000_0000, 1'b0);
        idle();
        repeat (4) @(negedge clk);
        check("pending_responses", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
